stream_reduce_multi: RTL and testbench
======================================

Name: stream_reduce_multi

Overview:
- Parametrised sparse-stream reducer; successor of the fixed 16-bit add-only reduce inside the reduce/PE cluster.
- Consumes a ready/valid stream of values interleaved with stop and done tokens, reduces each segment, and emits the result followed by a level-decremented stop token.
- Adds runtime-selectable op (add/max/min), optional signed saturation, and a configurable value for empty segments.
- Sits between a tile_write-style producer and a tile_read-style consumer.

Parameters:
- DATA_WIDTH, 16, payload width; stream word is DATA_WIDTH+1 bits, MSB = token flag.
- DONE_CODE, 16'h0100, low-bit payload identifying the done token.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low (one clock; reset is asynchronous and active-low)
- clk_en  in  1  global clock enable; 0 freezes all state
- flush  in  1  synchronous clear, same effect as reset
- tile_en  in  1  0 forces data_in_ready=0, data_out_valid=0, state held
- op_mode  in  2  0 add, 1 signed max, 2 signed min, 3 treated as add
- saturate  in  1  1 = signed saturating add
- default_value  in  DATA_WIDTH  value emitted for an empty segment
- data_in  in  DATA_WIDTH+1  input word
- data_in_valid  in  1  input valid
- data_in_ready  out  1  input ready
- data_out  out  DATA_WIDTH+1  output word
- data_out_valid  out  1  output valid
- data_out_ready  in  1  output ready

Behaviour:
- Encoding: MSB=0 is a value. MSB=1 with low bits == DONE_CODE is done (17'h10100 at default). MSB=1 with low bits < DONE_CODE is stop token S_n, n = low bits.
- Reset/flush: state=ACCUM, acc=0, has_val=0, data_out=0, data_out_valid=0, data_in_ready=0 during reset, 1 after.
- Transfers occur on a cycle where valid&ready are both high at a clk edge with clk_en=1 and tile_en=1.
- ACCUM: data_in_ready = !data_out_valid | data_out_ready.
  - Value accepted: acc = has_val ? op(acc, v) : v; has_val=1; no output.
  - S_n accepted: register out = {0, has_val ? acc : default_value}; data_out_valid=1 the next cycle; clear acc/has_val; go EMIT_TOK if n>0, else stay ACCUM.
  - Done accepted: register out = done token; go DONE_WAIT.
- EMIT_TOK: data_in_ready=0. When the value word handshakes, load {1, n-1}, keep valid, return to ACCUM.
- DONE_WAIT: data_in_ready=0. When done handshakes, return to ACCUM; acc already clear.
- Latency: 1 cycle from stop/done acceptance to data_out_valid. Result plus token costs 2 output beats; input is stalled meanwhile.
- data_out and data_out_valid must hold stable while valid && !ready.
- Arithmetic: two's complement.
  - Add with saturate=0 wraps mod 2^DATA_WIDTH.
  - Add with saturate=1 clamps to 2^(W-1)-1 or -2^(W-1).
  - max/min compare signed.
- op_mode and saturate are sampled per value; changing them mid-segment is allowed.
- Done with has_val=1 (segment not closed by a stop token): partial acc is discarded, only done is emitted.
- Flush mid-segment: acc discarded, no output produced, pending output dropped.
- Simultaneous input and output handshake in ACCUM is legal (full throughput on values).

Test Plan:
- 1,2,3,S0,done; op=add -> out 6, done; no stop token emitted for S0.
- 1,2,3,S2,done -> 6, S1, done (17'h00006, 17'h10001, 17'h10100).
- S0 alone, default_value=16'h00AA -> out 16'h00AA, then nothing until the next input.
- op=max: -3,7,-1,S0 -> 7. op=min on the same stream -> 16'hFFFD.
- Add: 16'h7FFF,1,S0 with saturate=0 -> 16'h8000; with saturate=1 -> 16'h7FFF.
- Random data_out_ready (RAN_SHIFT-style) over a 200-segment stream -> outputs match the golden file, none lost or duplicated.
- Flush asserted after 1,2 -> next stream 5,S0 gives 5.

Source files
------------

// File: rtl/stream_reduce_multi.sv
// Sparse-stream segment reducer: folds values with add/max/min (optional saturation)
// and emits the result plus a level-decremented stop token, or forwards done.
module stream_reduce_multi #(
    parameter int DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] DONE_CODE = 16'h0100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  tile_en,
    input  logic [1:0]            op_mode,
    input  logic                  saturate,
    input  logic [DATA_WIDTH-1:0] default_value,
    input  logic [DATA_WIDTH:0]   data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH:0]   data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);
    localparam int W = DATA_WIDTH;

    // state     | meaning
    // ST_ACCUM  | folding values, accepting stop/done
    // ST_EMIT   | result word pending, stop token S_{n-1} follows
    // ST_DWAIT  | done token pending
    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_EMIT  = 2'd1;
    localparam logic [1:0] ST_DWAIT = 2'd2;

    logic [1:0]   state;
    logic [W-1:0] acc;
    logic         has_val;
    logic [W:0]   out_reg;
    logic         out_valid;
    logic [W-1:0] tok_level;

    logic         in_tok;
    logic [W-1:0] in_low;
    logic         in_done;
    logic         fire_in;
    logic         fire_out;
    logic [W-1:0] sum;
    logic         ovf;
    logic [W-1:0] add_res;
    logic [W-1:0] op_res;
    logic [W-1:0] next_acc;

    assign in_tok  = data_in[W];
    assign in_low  = data_in[W-1:0];
    assign in_done = in_tok && (in_low == DONE_CODE);

    assign data_in_ready  = rst_n && tile_en && (state == ST_ACCUM) && (!out_valid || data_out_ready);
    assign data_out_valid = out_valid && tile_en;
    assign data_out       = out_reg;

    assign fire_in  = clk_en && tile_en && data_in_valid && data_in_ready;
    assign fire_out = clk_en && tile_en && out_valid && data_out_ready;

    // Signed overflow: operands share a sign that the wrapped sum does not.
    assign sum = acc + in_low;
    assign ovf = (acc[W-1] == in_low[W-1]) && (sum[W-1] != acc[W-1]);

    always_comb begin
        add_res = sum;
        if (saturate && ovf)
            add_res = acc[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        case (op_mode)
            2'd1:    op_res = ($signed(in_low) > $signed(acc)) ? in_low : acc;
            2'd2:    op_res = ($signed(in_low) < $signed(acc)) ? in_low : acc;
            default: op_res = add_res;
        endcase
        next_acc = has_val ? op_res : in_low;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            has_val   <= 1'b0;
            out_reg   <= '0;
            out_valid <= 1'b0;
            tok_level <= '0;
        end else if (clk_en) begin
            if (flush) begin
                state     <= ST_ACCUM;
                acc       <= '0;
                has_val   <= 1'b0;
                out_reg   <= '0;
                out_valid <= 1'b0;
                tok_level <= '0;
            end else if (tile_en) begin
                case (state)
                    ST_ACCUM: begin
                        if (fire_out)
                            out_valid <= 1'b0;
                        if (fire_in) begin
                            if (!in_tok) begin
                                acc     <= next_acc;
                                has_val <= 1'b1;
                            end else if (in_done) begin
                                out_reg   <= {1'b1, DONE_CODE};
                                out_valid <= 1'b1;
                                acc       <= '0;
                                has_val   <= 1'b0;
                                state     <= ST_DWAIT;
                            end else begin
                                out_reg   <= {1'b0, has_val ? acc : default_value};
                                out_valid <= 1'b1;
                                acc       <= '0;
                                has_val   <= 1'b0;
                                if (in_low != '0) begin
                                    tok_level <= in_low - 1'b1;
                                    state     <= ST_EMIT;
                                end
                            end
                        end
                    end
                    ST_EMIT: begin
                        if (fire_out) begin
                            out_reg <= {1'b1, tok_level};
                            state   <= ST_ACCUM;
                        end
                    end
                    ST_DWAIT: begin
                        if (fire_out) begin
                            out_valid <= 1'b0;
                            state     <= ST_ACCUM;
                        end
                    end
                    default: state <= ST_ACCUM;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_stream_reduce_multi.sv
// Directed bench for stream_reduce_multi: hand-computed segment results collected
// from the output handshake and compared in order.
module tb_stream_reduce_multi;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        flush = 1'b0;
    logic        tile_en = 1'b1;
    logic [1:0]  op_mode = 2'd0;
    logic        saturate = 1'b0;
    logic [15:0] default_value = 16'h0000;
    logic [16:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic        data_in_ready;
    logic [16:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready = 1'b1;

    int          passes = 0;
    int          total = 0;
    logic [16:0] outq[$];
    bit          rnd_en = 1'b0;
    bit          man_ready = 1'b1;
    bit          prev_hold = 1'b0;
    logic [16:0] prev_word = '0;

    localparam logic [16:0] DONE = 17'h10100;

    stream_reduce_multi dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .op_mode(op_mode), .saturate(saturate), .default_value(default_value),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    always @(posedge clk) begin
        #1;
        data_out_ready = rnd_en ? 1'($urandom_range(1, 0)) : man_ready;
    end

    // Output capture plus hold-stability check while stalled.
    always @(negedge clk) begin
        if (rst_n && !flush && tile_en && clk_en) begin
            if (prev_hold) begin
                check("hold_valid", {31'b0, data_out_valid}, 32'd1);
                check("hold_data", {15'b0, data_out}, {15'b0, prev_word});
            end
            if (data_out_valid && data_out_ready)
                outq.push_back(data_out);
            prev_hold = data_out_valid && !data_out_ready;
            prev_word = data_out;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic send(input logic [16:0] w);
        bit done_hs = 1'b0;
        data_in = w;
        data_in_valid = 1'b1;
        for (int i = 0; i < 200 && !done_hs; i++) begin
            @(negedge clk);
            if (data_in_ready && tile_en && clk_en) done_hs = 1'b1;
            @(posedge clk);
            #1;
        end
        data_in_valid = 1'b0;
        if (!done_hs) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [16:0] w);
        for (int i = 0; i < 300 && outq.size() == 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (outq.size() == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
        else check(tag, {15'b0, outq.pop_front()}, {15'b0, w});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_ready", {31'b0, data_in_ready}, 32'd0);
        check("rst_valid", {31'b0, data_out_valid}, 32'd0);
        check("rst_data", {15'b0, data_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        check("post_rst_ready", {31'b0, data_in_ready}, 32'd1);

        // sum with S0 then done: no stop token for S0
        send(17'd1); send(17'd2); send(17'd3); send(17'h10000); send(DONE);
        expect_out("s0_sum", 17'h00006);
        expect_out("s0_done", DONE);
        idle(5);
        check("s0_no_tok", outq.size(), 32'd0);

        send(17'd1); send(17'd2); send(17'd3); send(17'h10002); send(DONE);
        expect_out("s2_sum", 17'h00006);
        expect_out("s2_tok", 17'h10001);
        expect_out("s2_done", DONE);

        default_value = 16'h00AA;
        send(17'h10000);
        expect_out("empty_default", 17'h000AA);
        idle(6);
        check("empty_quiet", outq.size(), 32'd0);

        op_mode = 2'd1;
        send(17'h0FFFD); send(17'h00007); send(17'h0FFFF); send(17'h10000);
        expect_out("max", 17'h00007);
        op_mode = 2'd2;
        send(17'h0FFFD); send(17'h00007); send(17'h0FFFF); send(17'h10000);
        expect_out("min", 17'h0FFFD);
        op_mode = 2'd3;
        send(17'd4); send(17'd5); send(17'h10000);
        expect_out("op3_add", 17'h00009);
        op_mode = 2'd0;

        saturate = 1'b0;
        send(17'h07FFF); send(17'h00001); send(17'h10000);
        expect_out("wrap_pos", 17'h08000);
        saturate = 1'b1;
        send(17'h07FFF); send(17'h00001); send(17'h10000);
        expect_out("sat_pos", 17'h07FFF);
        send(17'h08000); send(17'h0FFFF); send(17'h10000);
        expect_out("sat_neg", 17'h08000);
        saturate = 1'b0;
        send(17'h08000); send(17'h0FFFF); send(17'h10000);
        expect_out("wrap_neg", 17'h07FFF);

        // partial segment closed by done: only done emitted
        send(17'd4); send(DONE);
        expect_out("partial_done", DONE);
        idle(4);
        check("partial_quiet", outq.size(), 32'd0);

        send(17'd1); send(17'd2);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        send(17'd5); send(17'h10000);
        expect_out("after_flush", 17'h00005);

        // tile_en gating a pending output
        man_ready = 1'b0;
        send(17'd9); send(17'h10000);
        idle(1);
        tile_en = 1'b0;
        #1;
        check("tile_off_valid", {31'b0, data_out_valid}, 32'd0);
        check("tile_off_ready", {31'b0, data_in_ready}, 32'd0);
        idle(3);
        tile_en = 1'b1;
        #1;
        check("tile_on_valid", {31'b0, data_out_valid}, 32'd1);
        check("tile_on_data", {15'b0, data_out}, 32'h00009);
        man_ready = 1'b1;
        expect_out("tile_out", 17'h00009);

        // random back-pressure: each segment i,1,S1 -> i+1 then S0
        rnd_en = 1'b1;
        fork
            for (int i = 0; i < 40; i++) begin
                send(17'(i)); send(17'd1); send(17'h10001);
            end
            for (int i = 0; i < 40; i++) begin
                expect_out("rnd_val", 17'(i + 1));
                expect_out("rnd_tok", 17'h10000);
            end
        join
        rnd_en = 1'b0;
        idle(10);
        check("final_empty", outq.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
